// File: rtl/ysyx_22040237_dmem_responder.sv
// Data-memory responder for the LSU: one request at a time, fixed access
// latency, then a held valid/ready response carrying load data or a fault.
//
// Handshakes: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; a response transfers on a rising edge where
// rsp_valid_o and rsp_ready_i are both 1. Once raised, rsp_valid_o and the
// rsp_* payload stay constant until that transfer.
module ysyx_22040237_dmem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [63:0] req_addr_i,
  input  logic [7:0]  req_wmask_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wen_q, wen_d;
  logic [63:0]     addr_q, addr_d;
  logic [7:0]      mask_q, mask_d;
  logic [63:0]     wdata_q, wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [63:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [63:0]     mem [0:DEPTH-1];

  logic                  enter_resp;
  logic                  src_wen;
  logic [63:0]           src_addr;
  logic [7:0]            src_mask;
  logic [63:0]           src_wdata;
  logic [63:0]           off;
  logic [2:0]            byte_sel;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [15:0]           mask_sh;
  logic [63:0]           wdata_sh;
  logic [63:0]           rd_shifted;
  logic                  fault;
  logic                  mem_we;

  // Access evaluation; with LATENCY==1 the response is built on the accept
  // edge itself, so the live request inputs are used while in IDLE.
  always_comb begin
    src_wen    = (state_q == S_IDLE) ? req_wen_i   : wen_q;
    src_addr   = (state_q == S_IDLE) ? req_addr_i  : addr_q;
    src_mask   = (state_q == S_IDLE) ? req_wmask_i : mask_q;
    src_wdata  = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
    off        = src_addr - BASE_ADDR;
    byte_sel   = off[2:0];
    word_idx   = off[DEPTH_LOG2+2:3];
    mask_sh    = {8'b0, src_mask} << byte_sel;
    wdata_sh   = src_wdata << {byte_sel, 3'b000};
    rd_shifted = mem[word_idx] >> {byte_sel, 3'b000};
    // Out of range (including wrap below BASE_ADDR) or a store spilling
    // into the next word.
    fault      = (|off[63:DEPTH_LOG2+3]) || (src_wen && (|mask_sh[15:8]));
    // rst gating keeps a request held during reset from ever writing.
    mem_we     = enter_resp && src_wen && !fault && rst;
  end

  // Next-state, request capture and response payload.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          wen_d   = req_wen_i;
          addr_d  = req_addr_i;
          mask_d  = req_wmask_i;
          wdata_d = req_wdata_i;
          cnt_d   = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fault;
      rsp_rdata_d = (fault || src_wen) ? 64'd0 : rd_shifted;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wen_q       <= 1'b0;
      addr_q      <= 64'd0;
      mask_q      <= 8'd0;
      wdata_q     <= 64'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-masked store commit; the array has no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (mask_sh[i]) mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_22040237_dmem_responder.sv
// Bench for the data-memory responder: reference memory model, expected
// response queue, directed scenarios plus a randomised mix.
module tb_ysyx_22040237_dmem_responder;

  localparam int          DEPTH_LOG2 = 10;
  localparam int          LATENCY    = 2;
  localparam logic [63:0] BASE       = 64'h8000_0000;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wen_i;
  logic [63:0] req_addr_i;
  logic [7:0]  req_wmask_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [1:0]  dbg_state_o;

  logic [64:0] exp_q[$];
  logic [63:0] ref_mem [0:DEPTH-1];
  int          total;
  int          bad;

  ysyx_22040237_dmem_responder #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .LATENCY   (LATENCY),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_wen_i  (req_wen_i),
    .req_addr_i (req_addr_i),
    .req_wmask_i(req_wmask_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: returns {err, rdata} and applies a legal store.
  function automatic logic [64:0] model(input logic wen, input logic [63:0] addr,
                                        input logic [7:0] mask, input logic [63:0] wdata);
    logic [63:0] off;
    logic [63:0] r;
    int b;
    int idx;
    off = addr - BASE;
    if (off >= 64'(8 * DEPTH)) return {1'b1, 64'd0};
    b   = int'(off[2:0]);
    idx = int'(off[DEPTH_LOG2+2:3]);
    if (wen) begin
      for (int i = 0; i < 8; i++) if (mask[i] && (b + i > 7)) return {1'b1, 64'd0};
      for (int i = 0; i < 8; i++) if (mask[i]) ref_mem[idx][8*(b+i) +: 8] = wdata[8*i +: 8];
      return {1'b0, 64'd0};
    end
    r = 64'd0;
    for (int i = 0; i + b < 8; i++) r[8*i +: 8] = ref_mem[idx][8*(b+i) +: 8];
    return {1'b0, r};
  endfunction

  // One complete transaction, entered and left just after a falling edge.
  // stall = cycles of rsp_ready_i=0 once the response is up; junk = drive an
  // extra request during the wait that must be ignored.
  task automatic do_req(input logic wen, input logic [63:0] addr, input logic [7:0] mask,
                        input logic [63:0] wdata, input int stall, input logic junk);
    logic [64:0] exp;
    int k;
    logic seen;
    req_valid_i = 1'b1;
    req_wen_i   = wen;
    req_addr_i  = addr;
    req_wmask_i = mask;
    req_wdata_i = wdata;
    rsp_ready_i = (stall == 0);
    exp_q.push_back(model(wen, addr, mask, wdata));
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = junk;
    if (junk) begin
      req_wen_i   = 1'b1;
      req_addr_i  = BASE + 64'h8;
      req_wmask_i = 8'hFF;
      req_wdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    k = 1;
    seen = 1'b0;
    while (k <= 20 && !seen) begin
      if (rsp_valid_o === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rsp_timeout: got no rsp_valid want rsp_valid within 20 cycles");
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      void'(exp_q.pop_front());
      return;
    end
    if (k != LATENCY) begin
      bad++;
      $display("FAIL rsp_latency: got %0d want %0d", k, LATENCY);
    end
    exp = exp_q.pop_front();
    total++;
    if ({rsp_err_o, rsp_rdata_o} !== exp || dbg_state_o !== 2'd2) begin
      bad++;
      $display("FAIL rsp_data addr=%h: got err=%b rdata=%h st=%0d want err=%b rdata=%h st=2",
               addr, rsp_err_o, rsp_rdata_o, dbg_state_o, exp[64], exp[63:0]);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      total++;
      if (rsp_valid_o !== 1'b1 || {rsp_err_o, rsp_rdata_o} !== exp || req_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: got v=%b err=%b rdata=%h rdy=%b want v=1 err=%b rdata=%h rdy=0",
                 rsp_valid_o, rsp_err_o, rsp_rdata_o, req_ready_o, exp[64], exp[63:0]);
      end
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rsp_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    req_valid_i = 1'b0;
    req_wen_i   = 1'b0;
    req_addr_i  = 64'd0;
    req_wmask_i = 8'd0;
    req_wdata_i = 64'd0;
    rsp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_rdata_o !== 64'd0 ||
        rsp_err_o !== 1'b0 || dbg_state_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b rdy=%b rdata=%h err=%b st=%0d want 0 1 0 0 0",
               rsp_valid_o, req_ready_o, rsp_rdata_o, rsp_err_o, dbg_state_o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Request held valid through reset must never commit.
  task automatic test_reset_hold();
    do_req(1'b1, BASE + 64'h20, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 0, 1'b0);
    rst         = 1'b0;
    req_valid_i = 1'b1;
    req_wen_i   = 1'b1;
    req_addr_i  = BASE + 64'h20;
    req_wmask_i = 8'hFF;
    req_wdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold_valid: got %b want 0", rsp_valid_o);
      end
    end
    rst = 1'b1;
    req_valid_i = 1'b0;
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready_o);
    end
    do_req(1'b0, BASE + 64'h20, 8'h00, 64'd0, 0, 1'b0);
  endtask

  task automatic test_store_load();
    do_req(1'b1, BASE + 64'h8, 8'hFF, 64'h1122_3344_5566_7788, 0, 1'b0);
    do_req(1'b0, BASE + 64'h8, 8'h00, 64'd0, 0, 1'b0);
    do_req(1'b1, BASE + 64'hB, 8'h01, 64'h0000_0000_0000_00AB, 0, 1'b0);
    do_req(1'b0, BASE + 64'h8, 8'h00, 64'd0, 0, 1'b0);
    do_req(1'b0, BASE + 64'hB, 8'h00, 64'd0, 0, 1'b0);
    do_req(1'b1, BASE + 64'h8, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    do_req(1'b0, BASE + 64'h8, 8'h00, 64'd0, 0, 1'b0);
  endtask

  task automatic test_faults();
    do_req(1'b1, BASE,          8'hFF, 64'hA5A5_5A5A_C3C3_3C3C, 0, 1'b0);
    do_req(1'b1, BASE + 64'h6,  8'h0F, 64'h0000_0000_FFEE_DDCC, 0, 1'b0);
    do_req(1'b0, BASE,          8'h00, 64'd0, 0, 1'b0);
    do_req(1'b0, BASE + 64'h8,  8'h00, 64'd0, 0, 1'b0);
    do_req(1'b0, 64'h7FFF_FFF8, 8'h00, 64'd0, 0, 1'b0);
    do_req(1'b0, BASE + 64'(8 * DEPTH), 8'h00, 64'd0, 0, 1'b0);
    do_req(1'b1, BASE + 64'(8 * DEPTH), 8'h01, 64'h77, 0, 1'b0);
    do_req(1'b1, BASE + 64'(8 * DEPTH - 8), 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
    do_req(1'b0, BASE + 64'(8 * DEPTH - 1), 8'h00, 64'd0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_req(1'b0, BASE + 64'h8, 8'h00, 64'd0, 5, 1'b1);
    do_req(1'b0, BASE + 64'h8, 8'h00, 64'd0, 0, 1'b0);
  endtask

  task automatic test_reset_busy_resp();
    do_req(1'b1, BASE + 64'h10, 8'hFF, 64'h1357_9BDF_2468_ACE0, 0, 1'b0);
    req_valid_i = 1'b1;
    req_wen_i   = 1'b1;
    req_addr_i  = BASE + 64'h10;
    req_wmask_i = 8'hFF;
    req_wdata_i = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    req_valid_i = 1'b0;
    total++;
    if (dbg_state_o !== 2'd1) begin
      bad++;
      $display("FAIL busy_state: got %0d want 1", dbg_state_o);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (rsp_valid_o !== 1'b0 || dbg_state_o !== 2'd0) begin
      bad++;
      $display("FAIL busy_reset_drop: got v=%b st=%0d want v=0 st=0", rsp_valid_o, dbg_state_o);
    end
    do_req(1'b0, BASE + 64'h10, 8'h00, 64'd0, 0, 1'b0);
    // Reset while a response is waiting for ready.
    req_valid_i = 1'b1;
    req_wen_i   = 1'b0;
    req_addr_i  = BASE + 64'h10;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (LATENCY - 1) @(negedge clk);
    total++;
    if (rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL resp_before_reset: got %b want 1", rsp_valid_o);
    end
    rst = 1'b0;
    #1;
    total++;
    if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 64'd0) begin
      bad++;
      $display("FAIL resp_reset_lost: got v=%b rdata=%h want v=0 rdata=0", rsp_valid_o, rsp_rdata_o);
    end
    @(negedge clk);
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL resp_reset_idle: got rdy=%b v=%b want rdy=1 v=0", req_ready_o, rsp_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] masks [0:3];
    masks[0] = 8'h01;
    masks[1] = 8'h03;
    masks[2] = 8'h0F;
    masks[3] = 8'hFF;
    for (int w = 8; w < 16; w++)
      do_req(1'b1, BASE + 64'(8 * w), 8'hFF, {$urandom, $urandom}, 0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      do_req(1'($urandom_range(0, 1)),
             BASE + 64'(8 * $urandom_range(8, 15) + $urandom_range(0, 7)),
             masks[$urandom_range(0, 3)], {$urandom, $urandom},
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_store_load();
    test_reset_hold();
    test_faults();
    test_backpressure();
    test_reset_busy_resp();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
